// File: rtl/uart_tx_mmio.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_mmio
//  Description : Memory-mapped 8N1 UART transmitter for the CPU I/O window.
//                One-entry holding register in front of the shift register,
//                with a status word of {overrun, hold_full, busy}.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_mmio #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        memwrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] writedata_i,
  output logic [31:0] readdata_o,
  output logic        tx_o,
  output logic        busy_o
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] C_CNT_RELOAD = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      hold_q, hold_d;
  logic            hold_full_q, hold_full_d;
  logic            overrun_q, overrun_d;
  logic            tx_q, tx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;

  logic            drain;      // FSM takes the held byte this cycle
  logic            accept;     // DATA write stored into the holding register
  logic            sel_data;
  logic            sel_stat;
  logic            data_wr;
  logic            stat_clr;

  // Address bits outside the decoded set and the upper store data are not used.
  logic            unused_bits;
  assign unused_bits = ^{addr_i[31:9], addr_i[7:6], addr_i[3:0], writedata_i[31:8]};

  assign sel_data = addr_i[8] & addr_i[4];
  assign sel_stat = addr_i[8] & addr_i[5];
  assign data_wr  = memwrite_i & sel_data;
  assign stat_clr = memwrite_i & sel_stat & writedata_i[2];

  assign busy_o     = (state_q != S_IDLE);
  assign tx_o       = tx_q;
  assign readdata_o = sel_stat ? {29'b0, overrun_q, hold_full_q, busy_o} : 32'b0;

  // Frame sequencing: baud counter, bit index, shift register and line level.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    drain   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (hold_full_q) begin
          drain   = 1'b1;
          shift_d = hold_q;
          cnt_d   = C_CNT_RELOAD;
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_q == '0) begin
          cnt_d   = C_CNT_RELOAD;
          bit_d   = 3'd0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == '0) begin
          cnt_d = C_CNT_RELOAD;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_q == '0) begin
          if (hold_full_q) begin
            // Back-to-back: the next start bit follows the stop bit directly.
            drain   = 1'b1;
            shift_d = hold_q;
            cnt_d   = C_CNT_RELOAD;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The line is registered, so drive the level belonging to the next state.
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // Holding register and sticky overrun; a drain frees the slot for a same-cycle write.
  always_comb begin
    accept      = data_wr & (~hold_full_q | drain);
    hold_d      = accept ? writedata_i[7:0] : hold_q;
    hold_full_d = accept ? 1'b1 : (drain ? 1'b0 : hold_full_q);
    overrun_d   = (data_wr & ~accept) ? 1'b1 : (stat_clr ? 1'b0 : overrun_q);
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      shift_q     <= 8'd0;
      hold_q      <= 8'd0;
      hold_full_q <= 1'b0;
      overrun_q   <= 1'b0;
      tx_q        <= 1'b1;
      cnt_q       <= '0;
      bit_q       <= 3'd0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      overrun_q   <= overrun_d;
      tx_q        <= tx_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
    end
  end

endmodule
`default_nettype wire
